// File: rtl/tile_game_pkg.sv
// Shared definitions for the tile game: FSM state codes and default timing constants,
// used by the sequencer, the datapath and the bench.
package tile_game_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLEAR     = 4'd1,
    DRAW      = 4'd2,
    HOLD      = 4'd3,
    HIT       = 4'd4,
    MISS      = 4'd5,
    ADVANCE   = 4'd6,
    EDGE      = 4'd7,
    EDGE_FAIL = 4'd8,
    SHIFT     = 4'd9,
    OVER      = 4'd10
  } tile_state_e;

  localparam int DEF_ROW_PX    = 40;
  localparam int DEF_WAIT_INIT = 833333;
  localparam int DEF_WAIT_MIN  = 200000;
  localparam int DEF_WAIT_STEP = 50000;

endpackage

// File: rtl/tile_game_sequencer_if.sv
// Go/done handshake bundle between the tile game sequencer (master) and the
// clear/draw/hit/miss/colour/shift datapath units (slave).
interface tile_game_sequencer_if;
  logic clear_go,   draw_go,   hit_go,   miss_go,   colour_go,   shift_go;
  logic clear_done, draw_done, hit_done, miss_done, colour_done, shift_done;
  logic offset_inc;

  modport master (
    output clear_go, draw_go, hit_go, miss_go, colour_go, shift_go, offset_inc,
    input  clear_done, draw_done, hit_done, miss_done, colour_done, shift_done
  );

  modport slave (
    input  clear_go, draw_go, hit_go, miss_go, colour_go, shift_go, offset_inc,
    output clear_done, draw_done, hit_done, miss_done, colour_done, shift_done
  );
endinterface

// File: rtl/tile_speed_ctrl.sv
// Hold-period controller: counts hits and shortens the hold period by WAIT_STEP
// every SPEEDUP_EVERY hits, never going below WAIT_MIN.
module tile_speed_ctrl
  import tile_game_pkg::*;
#(
  parameter int WAIT_W        = 24,
  parameter int WAIT_INIT     = DEF_WAIT_INIT,
  parameter int WAIT_MIN      = DEF_WAIT_MIN,
  parameter int WAIT_STEP     = DEF_WAIT_STEP,
  parameter int SPEEDUP_EVERY = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              hit_pulse,
  output logic [WAIT_W-1:0] period
);
  localparam int CNT_W = $clog2(SPEEDUP_EVERY + 1);
  localparam int SUM_W = WAIT_W + 1;

  logic [CNT_W-1:0]  hit_cnt_reg;
  logic [WAIT_W-1:0] period_reg;
  logic [WAIT_W-1:0] period_next;
  logic [SUM_W-1:0]  stepped;

  // One spare bit: a borrow out of the subtraction shows up as the MSB.
  assign stepped = {1'b0, period_reg} - SUM_W'(WAIT_STEP);

  always_comb begin
    period_next = stepped[WAIT_W-1:0];
    if (stepped[WAIT_W] || (stepped < SUM_W'(WAIT_MIN)))
      period_next = WAIT_W'(WAIT_MIN);
  end

  always_ff @(posedge clock) begin
    if (!resetn || load) begin
      hit_cnt_reg <= '0;
      period_reg  <= WAIT_W'(WAIT_INIT);
    end else if (hit_pulse) begin
      if (hit_cnt_reg == CNT_W'(SPEEDUP_EVERY - 1)) begin
        hit_cnt_reg <= '0;
        period_reg  <= period_next;
      end else begin
        hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign period = period_reg;
endmodule

// File: rtl/tile_game_sequencer.sv
// Tile game master FSM: sequences datapath units via go/done and owns offset, hold timer,
// score and lives. Define TILE_SEQ_PAUSE_EN to add a pause input that freezes HOLD.
module tile_game_sequencer
  import tile_game_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int ROW_PX        = DEF_ROW_PX,
  parameter int LIVES         = 3,
  parameter int SCORE_W       = 16,
  parameter int WAIT_W        = 24,
  parameter int WAIT_INIT     = DEF_WAIT_INIT,
  parameter int WAIT_MIN      = DEF_WAIT_MIN,
  parameter int WAIT_STEP     = DEF_WAIT_STEP,
  parameter int SPEEDUP_EVERY = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         start,
`ifdef TILE_SEQ_PAUSE_EN
  input  logic                         pause,
`endif
  tile_game_sequencer_if.master        hs,
  input  logic                         key_press,
  input  logic [$clog2(LANES)-1:0]     key_lane,
  input  logic [LANES-1:0]             bottom_row,
  output logic                         game_over,
  output logic [$clog2(ROW_PX)-1:0]    offset,
  output logic [SCORE_W-1:0]           score,
  output logic [$clog2(LIVES+1)-1:0]   lives,
  output logic [3:0]                   state
);
  localparam int LANE_W    = $clog2(LANES);
  localparam int ROW_PAD_W = 1 << LANE_W;
  localparam int OFF_W     = $clog2(ROW_PX);
  localparam int LIVES_W   = $clog2(LIVES + 1);

  localparam logic [3:0] ST_IDLE      = IDLE;
  localparam logic [3:0] ST_CLEAR     = CLEAR;
  localparam logic [3:0] ST_DRAW      = DRAW;
  localparam logic [3:0] ST_HOLD      = HOLD;
  localparam logic [3:0] ST_HIT       = HIT;
  localparam logic [3:0] ST_MISS      = MISS;
  localparam logic [3:0] ST_ADVANCE   = ADVANCE;
  localparam logic [3:0] ST_EDGE      = EDGE;
  localparam logic [3:0] ST_EDGE_FAIL = EDGE_FAIL;
  localparam logic [3:0] ST_SHIFT     = SHIFT;
  localparam logic [3:0] ST_OVER      = OVER;

  logic [3:0]         state_reg,  state_next;
  logic [OFF_W-1:0]   offset_reg, offset_next;
  logic [SCORE_W-1:0] score_reg,  score_next;
  logic [LIVES_W-1:0] lives_reg,  lives_next;
  logic [WAIT_W-1:0]  timer_reg,  timer_next;
  logic [WAIT_W-1:0]  period;
  logic               speed_load, hit_pulse, hold_run, key_hit, last_life;
  logic [LIVES_W-1:0] lives_dec;
  logic [ROW_PAD_W-1:0] row_pad;

  // Lanes that do not exist read as empty, so such a key counts as a miss.
  genvar gi;
  generate
    for (gi = 0; gi < ROW_PAD_W; gi++) begin : g_row_pad
      if (gi < LANES) begin : g_lane
        assign row_pad[gi] = bottom_row[gi];
      end else begin : g_pad
        assign row_pad[gi] = 1'b0;
      end
    end
  endgenerate

  assign key_hit   = row_pad[key_lane];
  assign last_life = (lives_reg <= LIVES_W'(1));
  assign lives_dec = (lives_reg == '0) ? '0 : lives_reg - LIVES_W'(1);

`ifdef TILE_SEQ_PAUSE_EN
  assign hold_run = !pause;
`else
  assign hold_run = 1'b1;
`endif

  tile_speed_ctrl #(
    .WAIT_W        (WAIT_W),
    .WAIT_INIT     (WAIT_INIT),
    .WAIT_MIN      (WAIT_MIN),
    .WAIT_STEP     (WAIT_STEP),
    .SPEEDUP_EVERY (SPEEDUP_EVERY)
  ) u_speed (
    .clock     (clock),
    .resetn    (resetn),
    .load      (speed_load),
    .hit_pulse (hit_pulse),
    .period    (period)
  );

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    score_next  = score_reg;
    lives_next  = lives_reg;
    timer_next  = timer_reg;
    speed_load  = 1'b0;
    hit_pulse   = 1'b0;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: if (hs.clear_done) begin
        state_next  = ST_DRAW;
        offset_next = '0;
        score_next  = '0;
        lives_next  = LIVES_W'(LIVES);
        speed_load  = 1'b1;
      end
      ST_DRAW: if (hs.draw_done) begin
        state_next = ST_HOLD;
        timer_next = period - WAIT_W'(1);
      end
      // The timer parks at zero, so a key taken on the last cycle returns for one more.
      ST_HOLD: if (hold_run) begin
        if (timer_reg != '0) timer_next = timer_reg - WAIT_W'(1);
        if (key_press)              state_next = key_hit ? ST_HIT : ST_MISS;
        else if (timer_reg == '0)   state_next = ST_ADVANCE;
      end
      ST_HIT: if (hs.hit_done) begin
        state_next = ST_HOLD;
        hit_pulse  = 1'b1;
        if (score_reg != '1) score_next = score_reg + SCORE_W'(1);
      end
      ST_MISS: if (hs.miss_done) begin
        lives_next = lives_dec;
        state_next = last_life ? ST_OVER : ST_HOLD;
      end
      ST_ADVANCE: begin
        if (offset_reg == OFF_W'(ROW_PX - 1)) begin
          offset_next = '0;
          state_next  = ST_EDGE;
        end else begin
          offset_next = offset_reg + OFF_W'(1);
          state_next  = ST_DRAW;
        end
      end
      ST_EDGE:      state_next = (bottom_row == '0) ? ST_SHIFT : ST_EDGE_FAIL;
      ST_EDGE_FAIL: if (hs.colour_done) begin
        lives_next = lives_dec;
        state_next = last_life ? ST_OVER : ST_SHIFT;
      end
      ST_SHIFT: if (hs.shift_done) state_next = ST_DRAW;
      ST_OVER:  if (start) state_next = ST_CLEAR;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg  <= ST_IDLE;
      offset_reg <= '0;
      score_reg  <= '0;
      lives_reg  <= LIVES_W'(LIVES);
      timer_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      score_reg  <= score_next;
      lives_reg  <= lives_next;
      timer_reg  <= timer_next;
    end
  end

  assign hs.clear_go   = (state_reg == ST_CLEAR);
  assign hs.draw_go    = (state_reg == ST_DRAW);
  assign hs.hit_go     = (state_reg == ST_HIT);
  assign hs.miss_go    = (state_reg == ST_MISS);
  assign hs.colour_go  = (state_reg == ST_EDGE_FAIL);
  assign hs.shift_go   = (state_reg == ST_SHIFT);
  assign hs.offset_inc = (state_reg == ST_ADVANCE);
  assign game_over     = (state_reg == ST_OVER);
  assign offset        = offset_reg;
  assign score         = score_reg;
  assign lives         = lives_reg;
  assign state         = state_reg;
endmodule

// File: tb/tb_tile_game_sequencer.sv
// Randomised game-play bench for tile_game_sequencer against a transaction-level model
// of score, lives, offset and hold duration (small ROW_PX/WAIT values, 3-bit score).
module tb_tile_game_sequencer;
  import tile_game_pkg::*;

  localparam int T_LANES     = 4;
  localparam int T_ROW_PX    = 4;
  localparam int T_LIVES     = 3;
  localparam int T_SCORE_W   = 3;
  localparam int T_WAIT_W    = 8;
  localparam int T_WAIT_INIT = 10;
  localparam int T_WAIT_MIN  = 3;
  localparam int T_WAIT_STEP = 4;
  localparam int T_SPEED     = 2;
  localparam int SCORE_MAX   = (1 << T_SCORE_W) - 1;
  localparam int CYC_CAP     = 20000;

  logic       clock, resetn, start, key_press, game_over;
  logic [1:0] key_lane, offset, lives;
  logic [3:0] bottom_row, state;
  logic [2:0] score;
`ifdef TILE_SEQ_PAUSE_EN
  logic       pause;
`endif

  tile_game_sequencer_if hs();

  tile_game_sequencer #(
    .LANES(T_LANES), .ROW_PX(T_ROW_PX), .LIVES(T_LIVES), .SCORE_W(T_SCORE_W),
    .WAIT_W(T_WAIT_W), .WAIT_INIT(T_WAIT_INIT), .WAIT_MIN(T_WAIT_MIN),
    .WAIT_STEP(T_WAIT_STEP), .SPEEDUP_EVERY(T_SPEED)
  ) dut (
    .clock(clock), .resetn(resetn), .start(start),
`ifdef TILE_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .hs(hs), .key_press(key_press), .key_lane(key_lane), .bottom_row(bottom_row),
    .game_over(game_over), .offset(offset), .score(score), .lives(lives), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  int n_checks = 0, n_pass = 0, cyc = 0;
  int m_score, m_lives, m_offset, m_period, m_hits, m_left;
  bit m_in_over = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Which go line each state owns, as {shift,colour,miss,hit,draw,clear}.
  function automatic logic [5:0] go_mask(input logic [3:0] st);
    case (st)
      CLEAR:     return 6'b000001;
      DRAW:      return 6'b000010;
      HIT:       return 6'b000100;
      MISS:      return 6'b001000;
      EDGE_FAIL: return 6'b010000;
      SHIFT:     return 6'b100000;
      default:   return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] go_vec();
    return {hs.shift_go, hs.colour_go, hs.miss_go, hs.hit_go, hs.draw_go, hs.clear_go};
  endfunction

  // Random done pulses on lines whose go is low must be ignored.
  task automatic drive_dones(input logic [3:0] st, input bit real_done);
    logic [5:0] v;
    v = 6'($urandom) & ~go_mask(st);
    if (real_done) v = v | go_mask(st);
    {hs.shift_done, hs.colour_done, hs.miss_done, hs.hit_done, hs.draw_done, hs.clear_done} = v;
  endtask

  task automatic clear_dones();
    {hs.shift_done, hs.colour_done, hs.miss_done, hs.hit_done, hs.draw_done, hs.clear_done} = 6'b0;
  endtask

  task automatic run_hs(input logic [3:0] st, input int delay);
    int go_cnt = 0;
    check("hs_state", int'(state), int'(st));
    check("hs_go_vec", int'(go_vec()), int'(go_mask(st)));
    for (int i = 0; i < delay; i++) begin
      if ((go_vec() & go_mask(st)) != 6'b0) go_cnt++;
      drive_dones(st, 1'b0);
      step();
      check("hs_wait", int'(state), int'(st));
    end
    if ((go_vec() & go_mask(st)) != 6'b0) go_cnt++;
    drive_dones(st, 1'b1);
    step();
    clear_dones();
    check("hs_go_cycles", go_cnt, delay + 1);
    $display("txn hs state=%0d go_cycles=%0d lives=%0d score=%0d", st, go_cnt, lives, score);
  endtask

  task automatic hold_idle(input int k);
    for (int i = 0; i < k; i++) begin
      key_lane   = 2'($urandom);
      bottom_row = 4'($urandom);
      drive_dones(HOLD, 1'b0);
      step();
      check("hold_wait", int'(state), int'(HOLD));
    end
    clear_dones();
  endtask

  task automatic lose_life(output bit over);
    m_lives--;
    over = (m_lives == 0);
    check("lives", int'(lives), m_lives);
    if (over) begin
      check("to_over", int'(state), int'(OVER));
      check("game_over", int'(game_over), 1);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, int'(state), int'(IDLE));
    check({tag, "_go"}, int'(go_vec()), 0);
    check({tag, "_inc"}, int'(hs.offset_inc), 0);
    check({tag, "_score"}, int'(score), 0);
    check({tag, "_lives"}, int'(lives), T_LIVES);
    check({tag, "_offset"}, int'(offset), 0);
    check({tag, "_over"}, int'(game_over), 0);
  endtask

  task automatic start_game();
    check("start_from", int'(state), m_in_over ? int'(OVER) : int'(IDLE));
    check("start_over_flag", int'(game_over), int'(m_in_over));
    start = 1'b1;
    step();
    start = 1'b0;
    check("enter_clear", int'(state), int'(CLEAR));
    check("score_held", int'(score), m_score);
    run_hs(CLEAR, $urandom_range(0, 5));
    m_score = 0; m_lives = T_LIVES; m_offset = 0; m_period = T_WAIT_INIT; m_hits = 0;
    check("clear_to_draw", int'(state), int'(DRAW));
    check("clear_lives", int'(lives), m_lives);
    check("clear_score", int'(score), 0);
    check("clear_offset", int'(offset), 0);
  endtask

  task automatic play_game(input bit reset_on_hit);
    bit over = 1'b0;
    bit in_hold;
    int k;
    logic [1:0] lane;
    logic [3:0] row;
    start_game();
    while (!over && cyc < CYC_CAP) begin
      run_hs(DRAW, $urandom_range(0, 3));
      m_left = m_period;
      check("enter_hold", int'(state), int'(HOLD));
      in_hold = 1'b1;
      while (in_hold && !over && cyc < CYC_CAP) begin
        if ($urandom_range(0, 3) == 0) begin
          hold_idle(m_left - 1);
          step();
          check("advance", int'(state), int'(ADVANCE));
          check("offset_inc", int'(hs.offset_inc), 1);
          check("offset_pre", int'(offset), m_offset);
          row = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
          bottom_row = row;
          step();
          in_hold = 1'b0;
          if (m_offset == T_ROW_PX - 1) begin
            m_offset = 0;
            check("edge", int'(state), int'(EDGE));
            check("offset_wrap", int'(offset), 0);
            check("inc_one_cycle", int'(hs.offset_inc), 0);
            step();
            $display("txn edge row=%b", row);
            if (row != 4'b0000) begin
              check("edge_fail", int'(state), int'(EDGE_FAIL));
              run_hs(EDGE_FAIL, $urandom_range(0, 3));
              lose_life(over);
            end
            if (!over) run_hs(SHIFT, $urandom_range(0, 3));
          end else begin
            m_offset++;
            check("advance_draw", int'(state), int'(DRAW));
            check("offset_step", int'(offset), m_offset);
            $display("txn advance offset=%0d", offset);
          end
        end else begin
          k = ($urandom_range(0, 2) == 0) ? m_left - 1 : $urandom_range(0, m_left - 1);
          hold_idle(k);
          m_left -= k;
          lane = 2'($urandom);
          row  = 4'($urandom);
          key_lane = lane; bottom_row = row; key_press = 1'b1;
          step();
          key_press = 1'b0;
          m_left = (m_left > 1) ? m_left - 1 : 1;
          $display("txn key lane=%0d row=%b", lane, row);
          if (row[lane]) begin
            check("key_hit", int'(state), int'(HIT));
            if (reset_on_hit) begin
              check("hit_go_pre_reset", int'(hs.hit_go), 1);
              resetn = 1'b0;
              step();
              resetn = 1'b1;
              check_reset_state("mid_hit_reset");
              m_score = 0;
              over = 1'b1;
              m_in_over = 1'b0;
              return;
            end
            run_hs(HIT, $urandom_range(0, 3));
            m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
            m_hits++;
            if (m_hits == T_SPEED) begin
              m_hits = 0;
              m_period = (m_period - T_WAIT_STEP < T_WAIT_MIN) ? T_WAIT_MIN : m_period - T_WAIT_STEP;
            end
            check("score", int'(score), m_score);
            check("hit_back_hold", int'(state), int'(HOLD));
          end else begin
            check("key_miss", int'(state), int'(MISS));
            run_hs(MISS, $urandom_range(0, 3));
            lose_life(over);
            if (!over) check("miss_back_hold", int'(state), int'(HOLD));
          end
        end
      end
    end
    m_in_over = over;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; key_press = 1'b0; key_lane = '0; bottom_row = '0;
`ifdef TILE_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    clear_dones();
    step();
    step();
    check_reset_state("reset");
    resetn = 1'b1;
    step();
    check("idle_stays", int'(state), int'(IDLE));
    m_score = 0;
    play_game(1'b0);
    play_game(1'b0);
    play_game(1'b1);
    play_game(1'b0);
    play_game(1'b0);
    check("cycle_budget", int'(cyc < CYC_CAP), 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
